// File: rtl/sram_bus_responder_pkg.sv
// Shared definitions for the 16-bit external memory bus responder.
//   - memCtl strobe bit positions
//   - bus address/data widths
//   - responder read-path FSM states
package mem_bus_pkg;

    localparam int CTL_CE = 0;
    localparam int CTL_OE = 1;
    localparam int CTL_WE = 2;
    localparam int CTL_LB = 3;
    localparam int CTL_UB = 4;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        TURN     = 2'd3
    } rsp_state_t;

endpackage

// File: rtl/sram_bus_responder_if.sv
// External memory bus bundle between the memory master and the responder.
//   memCtl     : {ub, lb, we, oe, ce} strobes, active-high
//   memAddr    : word address
//   memDataIn  : write data sampled from the bus
//   memDataOut : read data, valid while memDataOe/rdValid
//   memDataOe  : responder drives the shared data net
//   rdValid    : memDataOut holds data for the current read
//   busy       : reset sweep in progress, commands ignored
//   busErr     : sticky oe+we conflict flag
//   rdCount    : accepted reads (wrapping)
//   wrCount    : committed write cycles (wrapping)
interface sram_bus_responder_if;
    import mem_bus_pkg::*;

    logic [4:0]            memCtl;
    logic [MEM_ADDR_W-1:0] memAddr;
    logic [MEM_DATA_W-1:0] memDataIn;
    logic [MEM_DATA_W-1:0] memDataOut;
    logic                  memDataOe;
    logic                  rdValid;
    logic                  busy;
    logic                  busErr;
    logic [15:0]           rdCount;
    logic [15:0]           wrCount;

    modport master (
        output memCtl, memAddr, memDataIn,
        input  memDataOut, memDataOe, rdValid, busy, busErr, rdCount, wrCount
    );

    modport slave (
        input  memCtl, memAddr, memDataIn,
        output memDataOut, memDataOe, rdValid, busy, busErr, rdCount, wrCount
    );

endinterface

// File: rtl/sram_bus_responder_array.sv
// sram_byte_array: 2**ADDR_W x 16 synchronous single-port storage with a
// per-byte write enable. Read data is registered; on a write the registered
// read data reflects the newly written bytes (write-first).
//   clk   : clock
//   addr  : word address
//   wdata : write data
//   be    : byte write enable, [0] = bits 7:0, [1] = bits 15:8
//   rdata : registered read data
module sram_byte_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    input  logic [1:0]        be,
    output logic [15:0]       rdata
);

    logic [15:0] mem_q [2**ADDR_W];
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;

    always_comb begin
        rdata_d = {be[1] ? wdata[15:8] : mem_q[addr][15:8],
                   be[0] ? wdata[7:0]  : mem_q[addr][7:0]};
    end

    always_ff @(posedge clk) begin
        if (be[0]) mem_q[addr][7:0]  <= wdata[7:0];
        if (be[1]) mem_q[addr][15:8] <= wdata[15:8];
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_bus_responder.sv
// sram_bus_responder: device side of the 16-bit external memory bus.
// Commits byte-masked writes at the sampling edge, answers reads after
// READ_LAT edges, and only drives data inside the read window.
//   CLK   : clock
//   RESET : synchronous active-high reset
//   bus   : memory bus bundle (slave side), see sram_bus_responder_if
module sram_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 2,
    parameter int INIT_ZERO = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sram_bus_responder_if.slave  bus
);

    localparam logic [1:0] LAT_LOAD  = 2'(READ_LAT - 1);
    localparam logic       INIT_BUSY = (INIT_ZERO != 0);

    rsp_state_t            state_q, state_d;
    logic [1:0]            lat_q, lat_d;
    logic [MEM_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]            rd_lanes_q, rd_lanes_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic                  busy_q, busy_d;
    logic [ADDR_W-1:0]     sweep_q, sweep_d;
    logic                  bus_err_q, bus_err_d;

    logic [1:0]            lanes;
    logic                  active, rd_cmd, wr_cmd, conflict, same_rd, accept, drive;
    logic [ADDR_W-1:0]     arr_addr;
    logic [15:0]           arr_wdata, arr_rdata;
    logic [1:0]            arr_be;

    function automatic logic [15:0] mask_lanes(input logic [15:0] d, input logic [1:0] l);
        return {l[1] ? d[15:8] : 8'h00, l[0] ? d[7:0] : 8'h00};
    endfunction

    // Command decode: a sample with no lane strobe, ce low, during the sweep
    // or under reset does nothing at all.
    always_comb begin
        lanes    = {bus.memCtl[CTL_UB], bus.memCtl[CTL_LB]};
        active   = bus.memCtl[CTL_CE] & (|lanes) & ~busy_q & ~RESET;
        rd_cmd   = active &  bus.memCtl[CTL_OE] & ~bus.memCtl[CTL_WE];
        wr_cmd   = active & ~bus.memCtl[CTL_OE] &  bus.memCtl[CTL_WE];
        conflict = active &  bus.memCtl[CTL_OE] &  bus.memCtl[CTL_WE];
        same_rd  = (bus.memAddr == rd_addr_q) && (lanes == rd_lanes_q);
    end

    // Next-state logic. Any read that is not a continuation of the current
    // one (new address or lanes, or arriving from IDLE/TURN) is a new accept.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_cmd) accept = 1'b1;
            end
            RD_WAIT: begin
                if (rd_cmd && same_rd) begin
                    if (lat_q == 2'd0) state_d = RD_DRIVE;
                    else               lat_d   = lat_q - 2'd1;
                end else if (rd_cmd) begin
                    accept = 1'b1;
                end else begin
                    state_d = TURN;
                end
            end
            RD_DRIVE: begin
                if (rd_cmd && !same_rd) accept  = 1'b1;
                else if (!rd_cmd)       state_d = TURN;
            end
            TURN: begin
                if (rd_cmd) accept  = 1'b1;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = RD_WAIT;
            lat_d   = LAT_LOAD;
        end
    end

    always_comb begin
        rd_addr_d  = accept ? bus.memAddr : rd_addr_q;
        rd_lanes_d = accept ? lanes : rd_lanes_q;
        rd_count_d = rd_count_q + 16'(accept);
        wr_count_d = wr_count_q + 16'(wr_cmd);
        bus_err_d  = bus_err_q | conflict;
        busy_d     = busy_q;
        sweep_d    = sweep_q;
        if (busy_q) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) busy_d = 1'b0;
        end
    end

    // The sweep owns the array port while busy; otherwise the bus address
    // addresses it every cycle so a held read keeps refreshing its data.
    always_comb begin
        arr_addr  = busy_q ? sweep_q : bus.memAddr[ADDR_W-1:0];
        arr_wdata = busy_q ? 16'h0000 : bus.memDataIn;
        arr_be    = 2'b00;
        if (busy_q && !RESET) arr_be = 2'b11;
        else if (wr_cmd)      arr_be = lanes;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            lat_q      <= 2'd0;
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
            busy_q     <= INIT_BUSY;
            sweep_q    <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            busy_q     <= busy_d;
            sweep_q    <= sweep_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_ff @(posedge CLK) begin
        rd_addr_q  <= rd_addr_d;
        rd_lanes_q <= rd_lanes_d;
    end

    sram_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (CLK),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .rdata (arr_rdata)
    );

    // A write sample and an active driver must never overlap, so the drive
    // window closes combinationally as soon as a write appears.
    always_comb begin
        drive          = (state_q == RD_DRIVE) & ~wr_cmd;
        bus.memDataOe  = drive;
        bus.rdValid    = drive;
        bus.memDataOut = drive ? mask_lanes(arr_rdata, rd_lanes_q) : 16'h0000;
    end

    assign bus.busy    = busy_q;
    assign bus.busErr  = bus_err_q;
    assign bus.rdCount = rd_count_q;
    assign bus.wrCount = wr_count_q;

endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
- Device-side responder for the 16-bit external memory bus (memCtl/memAddr/memData) driven by the Kami design's memWrite/memRead methods.
- Decodes control strobes, services byte-masked writes into an internal array and returns read data after a fixed latency. Drives data only during a read window.
- Used as the on-board RAM model for simulation and as an FPGA BRAM stand-in. The system top wires memDataOut/memDataOe onto the shared memData net.

Parameters:
- ADDR_W, 10, implemented address bits; array depth 2**ADDR_W words; memAddr[15:ADDR_W] ignored (aliasing).
- READ_LAT, 2, cycles from accepted read command to data valid; legal range 1..4.
- INIT_ZERO, 1, 1 = array cleared to 0 by the reset sweep; 0 = no sweep.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- memCtl  in  5  [0] ce, [1] oe, [2] we, [3] lb (byte 7:0), [4] ub (byte 15:8); all active-high; idle = 0.
- memAddr  in  16  word address.
- memDataIn  in  16  write data sampled from the bus.
- memDataOut  out  16  read data.
- memDataOe  out  1  high = responder drives memData.
- rdValid  out  1  memDataOut holds valid data for the current read.
- busy  out  1  reset sweep in progress; commands ignored.
- busErr  out  1  sticky: oe and we asserted together with ce.
- rdCount  out  16  accepted reads, wraps at 0xFFFF -> 0.
- wrCount  out  16  committed writes, wraps.

Behaviour:
- Reset: all outputs 0 except busy. busy=1 for 2**ADDR_W cycles when INIT_ZERO=1, else 0 the cycle after RESET deasserts. RESET mid-sweep restarts the sweep. RESET mid-read drops memDataOe in the same edge.
- Commands are sampled every rising edge. With ce=0, lb=ub=0, or busy=1 the sample is a no-op.
- Write (ce & we & ~oe): committed at that edge. Only lanes with lb/ub set are updated. wrCount++ per write cycle. A held strobe rewrites every cycle and counts each one.
- Read (ce & oe & ~we): FSM IDLE -> RD_WAIT. Latency counter loads READ_LAT-1.
- RD_WAIT: counter at 0 -> RD_DRIVE. Array data appears with memDataOe=1 and rdValid=1 exactly READ_LAT edges after the accepting edge.
- Unmasked lanes are driven as 0x00.
- rdCount++ once per accepted read, not per held cycle.
- RD_DRIVE: while the same address and strobes are held, data keeps updating. A write to the same address from another agent is not possible, so no hazard arises.
- Address or lane change while oe held: back to RD_WAIT, new accepted read, rdCount++.
- oe drop or ce drop in RD_WAIT/RD_DRIVE: -> TURN for one cycle with memDataOe=0, then IDLE.
- A write arriving in TURN is accepted normally, because a write never drives data from this block.
- Read arriving in TURN: accepted, goes to RD_WAIT.
- Conflict (ce & oe & we): busErr=1 until RESET. No array update, no counter change. FSM -> TURN if driving, else stays IDLE.
- memDataOe is never high in the same cycle as an accepted write sample. If a write sample is seen in RD_DRIVE, drop memDataOe that cycle and still commit.
- Read-after-write to the same address on consecutive cycles returns the new data (array write-first).

Decomposition:
- Package mem_bus_pkg:
  - memCtl bit index constants CTL_CE, CTL_OE, CTL_WE, CTL_LB, CTL_UB.
  - Width constants MEM_ADDR_W=16, MEM_DATA_W=16.
  - Enum rsp_state_t {IDLE, RD_WAIT, RD_DRIVE, TURN}.
- Sub-module sram_byte_array: 2**ADDR_W x 16 synchronous single-port array with 2-bit byte write enable and write-first read. The top holds the FSM, latency counter, stat counters, sweep counter and error flag.

Test Plan:
- Reset sweep, INIT_ZERO=1, ADDR_W=4: RESET 1 cycle -> busy high 16 cycles; read addr 0x0007 afterwards returns 0x0000; rdCount=1.
- Write 0xBEEF to 0x0012 with lb=ub=1, then read 0x0012 with READ_LAT=2 -> memDataOe and rdValid rise 2 edges after the accepting edge, memDataOut=0xBEEF; wrCount=1, rdCount=1.
- Byte mask: write 0x1234 to 0x0003 full, then 0xAB00 with ub only; read -> 0xAB34. Read with lb only -> 0x0034.
- Held read then oe drop: read 0x0001 for 6 cycles, drop oe -> memDataOe low one edge after the drop, TURN 1 cycle, rdCount=1. Address change mid-hold to 0x0002 -> rdValid low for READ_LAT cycles, rdCount=2.
- Conflict: memCtl=5'b11111 at 0x0005 holding 0x1111 -> busErr=1 sticky, array still 0x1111, counters unchanged; RESET clears busErr.
- Counter wrap: preload via 65535 writes, one more -> wrCount=0x0000. Read during RESET assertion -> memDataOe=0 at that edge.
